mesi_bus_arbiter: RTL and testbench

MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

---
 rtl/mesi_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_arbiter.sv
// Two-cache MESI snooping bus arbiter: round-robin grant, address broadcast,
// snoop resolution, memory fill or cache-to-cache flush, then a done pulse.
module mesi_bus_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_1,
    input  logic        req_2,
    input  logic [1:0]  cmd_1,
    input  logic [1:0]  cmd_2,
    input  logic [31:0] addr_1,
    input  logic [31:0] addr_2,
    input  logic        snoop_hit,
    input  logic        snoop_dirty,
    input  logic        flush_done,
    output logic        gnt_1,
    output logic        gnt_2,
    output logic        bus_valid,
    output logic [1:0]  bus_cmd,
    output logic [31:0] bus_addr,
    output logic        bus_owner,
    output logic        flush_req,
    output logic        done_1,
    output logic        done_2,
    output logic        shared,
    output logic        c2c
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        SNOOP = 3'd2,
        MEM   = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] CMD_RD   = 2'b00;
    localparam logic [1:0] CMD_UPGR = 2'b10;
    localparam logic [1:0] CMD_RSV  = 2'b11;
    localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;          // requester that wins the next tie (0 = cache 1)
    logic [3:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        owner_q, owner_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;

    logic gnt_1_q, gnt_1_d;
    logic gnt_2_q, gnt_2_d;
    logic bus_valid_q, bus_valid_d;
    logic flush_req_q, flush_req_d;
    logic done_1_q, done_1_d;
    logic done_2_q, done_2_d;
    logic shared_q, shared_d;
    logic c2c_q, c2c_d;

    logic is_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            hit_q       <= 1'b0;
            owner_q     <= 1'b0;
            cmd_q       <= 2'b00;
            addr_q      <= 32'd0;
            gnt_1_q     <= 1'b0;
            gnt_2_q     <= 1'b0;
            bus_valid_q <= 1'b0;
            flush_req_q <= 1'b0;
            done_1_q    <= 1'b0;
            done_2_q    <= 1'b0;
            shared_q    <= 1'b0;
            c2c_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            gnt_1_q     <= gnt_1_d;
            gnt_2_q     <= gnt_2_d;
            bus_valid_q <= bus_valid_d;
            flush_req_q <= flush_req_d;
            done_1_q    <= done_1_d;
            done_2_q    <= done_2_d;
            shared_q    <= shared_d;
            c2c_q       <= c2c_d;
        end
    end

    // Next-state logic; the owner's command/address are captured only at grant.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (req_1 || req_2) begin
                    owner_d = (req_1 && req_2) ? rr_q : req_2;
                    cmd_d   = owner_d ? cmd_2 : cmd_1;
                    addr_d  = owner_d ? addr_2 : addr_1;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = SNOOP;
            SNOOP: begin
                hit_d = snoop_hit;
                if (cmd_q == CMD_UPGR) begin
                    state_d = DONE;
                end else if (snoop_dirty) begin
                    state_d = FLUSH;
                end else if (snoop_hit) begin
                    state_d = DONE;
                end else begin
                    state_d = MEM;
                    cnt_d   = MEM_LOAD;
                end
            end
            MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = ~owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        is_read     = (cmd_d == CMD_RD) || (cmd_d == CMD_RSV);
        gnt_1_d     = (state_d != IDLE) && !owner_d;
        gnt_2_d     = (state_d != IDLE) && owner_d;
        bus_valid_d = (state_d == ADDR);
        flush_req_d = (state_d == FLUSH);
        done_1_d    = (state_d == DONE) && !owner_d;
        done_2_d    = (state_d == DONE) && owner_d;
        shared_d    = (state_d == DONE) && hit_d && is_read;
        c2c_d       = (state_d == DONE) &&
                      ((state_q == FLUSH) || ((state_q == SNOOP) && (cmd_q != CMD_UPGR)));
    end

    assign gnt_1     = gnt_1_q;
    assign gnt_2     = gnt_2_q;
    assign bus_valid = bus_valid_q;
    assign bus_cmd   = cmd_q;
    assign bus_addr  = addr_q;
    assign bus_owner = owner_q;
    assign flush_req = flush_req_q;
    assign done_1    = done_1_q;
    assign done_2    = done_2_q;
    assign shared    = shared_q;
    assign c2c       = c2c_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Self-checking bench for mesi_bus_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level model of the bus protocol.
module tb_mesi_bus_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_1 = 1'b0, req_2 = 1'b0;
    logic [1:0]  cmd_1 = 2'b00, cmd_2 = 2'b00;
    logic [31:0] addr_1 = 32'd0, addr_2 = 32'd0;
    logic        snoop_hit = 1'b0, snoop_dirty = 1'b0, flush_done = 1'b0;
    logic        gnt_1, gnt_2, bus_valid, bus_owner, flush_req;
    logic        done_1, done_2, shared, c2c;
    logic [1:0]  bus_cmd;
    logic [31:0] bus_addr;
    logic [42:0] outv;

    typedef struct packed {
        logic [1:0]  gnt_first;
        logic        own_first;
        logic        gnt_stable;
        logic [3:0]  vcnt;
        logic [7:0]  lat;
        logic [1:0]  done_vec;
        logic        shr;
        logic        c2c;
        logic [7:0]  fcnt;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  idle_bits;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit last_owner = 1'b1;   // owner of the latest grant; 1 makes cache 1 win the first tie

    mesi_bus_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_1(req_1), .req_2(req_2),
        .cmd_1(cmd_1), .cmd_2(cmd_2),
        .addr_1(addr_1), .addr_2(addr_2),
        .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .flush_done(flush_done),
        .gnt_1(gnt_1), .gnt_2(gnt_2),
        .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_owner(bus_owner), .flush_req(flush_req),
        .done_1(done_1), .done_2(done_2),
        .shared(shared), .c2c(c2c)
    );

    assign outv = {gnt_1, gnt_2, bus_valid, bus_cmd, bus_addr, bus_owner,
                   flush_req, done_1, done_2, shared, c2c};

    always #5 clk = ~clk;

    // Round-robin: a tie goes to the cache not granted last; a lone request wins outright.
    function automatic bit winner(input bit r1, input bit r2);
        return (r1 && r2) ? !last_owner : !r1;
    endfunction

    // Expected transaction outcome derived from the MESI bus rules.
    function automatic obs_t model(input bit own, input logic [1:0] c, input logic [31:0] a,
                                   input bit hit, input bit dirty, input int f);
        obs_t e;
        bit   rd;
        rd           = (c == 2'b00) || (c == 2'b11);
        e            = '0;
        e.gnt_first  = own ? 2'b01 : 2'b10;
        e.own_first  = own;
        e.gnt_stable = 1'b1;
        e.vcnt       = 4'd1;
        e.done_vec   = own ? 2'b01 : 2'b10;
        e.cmd        = c;
        e.addr       = a;
        if (c == 2'b10) begin
            e.lat = 8'd3;
        end else if (dirty) begin
            e.lat  = 8'(3 + f);
            e.c2c  = 1'b1;
            e.fcnt = 8'(f);
            e.shr  = hit && rd;
        end else if (hit) begin
            e.lat = 8'd3;
            e.c2c = 1'b1;
            e.shr = rd;
        end else begin
            e.lat = 8'(MEM_LAT + 3);
        end
        return e;
    endfunction

    // Runs one bus transaction from an IDLE-cycle negedge through the following IDLE cycle.
    task automatic serve(input bit hit, input bit dirty, input int f, input bit scramble,
                         output obs_t o);
        int   n;
        int   fc;
        bit   fin;
        logic [1:0] g;
        n = 0; fc = 0; fin = 1'b0;
        o = '0;
        o.gnt_stable = 1'b1;
        while (!fin && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            g = {gnt_1, gnt_2};
            if (n == 1) begin
                o.gnt_first = g;
                o.own_first = bus_owner;
                if (scramble) begin
                    if (bus_owner) begin cmd_2 = 2'($urandom); addr_2 = $urandom; end
                    else begin cmd_1 = 2'($urandom); addr_1 = $urandom; end
                end
            end else if (g !== o.gnt_first) begin
                o.gnt_stable = 1'b0;
            end
            if (bus_valid) o.vcnt++;
            if (flush_req) fc++;
            flush_done  = flush_req ? (fc == f) : 1'($urandom);
            snoop_hit   = (n == 2) ? hit : 1'($urandom);
            snoop_dirty = (n == 2) ? dirty : 1'($urandom);
            if (done_1 || done_2) begin
                o.lat      = 8'(n);
                o.done_vec = {done_1, done_2};
                o.shr      = shared;
                o.c2c      = c2c;
                o.cmd      = bus_cmd;
                o.addr     = bus_addr;
                o.fcnt     = 8'(fc);
                if (done_1) req_1 = 1'b0; else req_2 = 1'b0;
                fin = 1'b1;
            end
        end
        if (!fin) o.lat = 8'hFF;
        flush_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o.idle_bits = {gnt_1, gnt_2, done_1, done_2};
        $display("txn owner=%0d cmd=%0d lat=%0d shared=%0d c2c=%0d",
                 o.own_first, o.cmd, o.lat, o.shr, o.c2c);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        req_1 = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outv !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", outv);
        end
        req_1 = 1'b0;
        rst = 1'b0;
        last_owner = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_miss();
        obs_t o, e;
        req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'd5;
        e = model(1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1);
        serve(1'b0, 1'b0, 1, 1'b0, o);
        last_owner = 1'b0;
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL miss: got %h expected %h", o, e); end
        n_cmp++;
        if (o.lat !== 8'd7) begin n_bad++; $display("FAIL miss_latency: got %0d expected 7", o.lat); end
    endtask

    task automatic test_upgrade();
        obs_t o, e;
        req_1 = 1'b1; cmd_1 = 2'b10; addr_1 = 32'd5;
        e = model(1'b0, 2'b10, 32'd5, 1'b1, 1'b1, 2);
        serve(1'b1, 1'b1, 2, 1'b0, o);
        last_owner = 1'b0;
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL upgrade: got %h expected %h", o, e); end
    endtask

    task automatic test_dirty_hit();
        obs_t o, e;
        req_2 = 1'b1; cmd_2 = 2'b00; addr_2 = 32'd5;
        e = model(1'b1, 2'b00, 32'd5, 1'b1, 1'b1, 2);
        serve(1'b1, 1'b1, 2, 1'b0, o);
        last_owner = 1'b1;
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL dirty_hit: got %h expected %h", o, e); end
    endtask

    task automatic test_contention();
        obs_t o, e;
        bit   w;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_owner = 1'b1;
        for (int round = 0; round < 2; round++) begin
            req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'h100 + 32'(round);
            req_2 = 1'b1; cmd_2 = 2'b01; addr_2 = 32'h200 + 32'(round);
            for (int k = 0; k < 2; k++) begin
                w = winner(req_1, req_2);
                e = model(w, w ? cmd_2 : cmd_1, w ? addr_2 : addr_1, 1'b0, 1'b0, 1);
                serve(1'b0, 1'b0, 1, 1'b1, o);
                last_owner = w;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL contention_r%0d_k%0d: got %h expected %h", round, k, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        obs_t o, e;
        bit   w;
        req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'h40;
        e = model(1'b0, 2'b00, 32'h40, 1'b0, 1'b0, 1);
        serve(1'b0, 1'b0, 1, 1'b0, o);
        last_owner = 1'b0;
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL pre_reset_miss: got %h expected %h", o, e); end
        // Tie now favours cache 2; reset during its MEM phase must restore cache 1 priority.
        req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'h44;
        req_2 = 1'b1; cmd_2 = 2'b00; addr_2 = 32'h48;
        snoop_hit = 1'b0; snoop_dirty = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                n_cmp++;
                if ({gnt_1, gnt_2} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL tie_to_cache2: got %b expected 01", {gnt_1, gnt_2});
                end
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outv !== 43'd0) begin n_bad++; $display("FAIL async_reset: got %h expected 0", outv); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (outv !== 43'd0) begin n_bad++; $display("FAIL reset_hold: got %h expected 0", outv); end
        rst = 1'b0;
        last_owner = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w = winner(req_1, req_2);
            e = model(w, w ? cmd_2 : cmd_1, w ? addr_2 : addr_1, 1'b0, 1'b0, 1);
            serve(1'b0, 1'b0, 1, 1'b0, o);
            last_owner = w;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL after_reset_k%0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit   r1, r2, w, h, d;
        int   f;
        for (int it = 0; it < 40; it++) begin
            r1 = 1'($urandom);
            r2 = 1'($urandom);
            if (!r1 && !r2) r1 = 1'b1;
            req_1 = r1; cmd_1 = 2'($urandom); addr_1 = $urandom;
            req_2 = r2; cmd_2 = 2'($urandom); addr_2 = $urandom;
            for (int k = 0; k < ((r1 && r2) ? 2 : 1); k++) begin
                w = winner(req_1, req_2);
                h = 1'($urandom);
                d = 1'($urandom);
                f = $urandom_range(1, 4);
                e = model(w, w ? cmd_2 : cmd_1, w ? addr_2 : addr_1, h, d, f);
                serve(h, d, f, 1'b1, o);
                last_owner = w;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL random_%0d_%0d: got %h expected %h", it, k, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_upgrade();
        test_dirty_hit();
        test_contention();
        test_reset_mid_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
